// File: rtl/argmax_pkg.sv
// -----------------------------------------------------------------------------
// argmax_pkg
// Shared types and constant helpers for the argmax classifier result stage.
//   state_t  : controller states (IDLE, ISSUE, DRAIN, DONE)
//   clog2    : ceiling log2, used for counter and index widths
//   most_neg : most-negative two's-complement value of a given width; it is
//              the starting value of the running maximum
// -----------------------------------------------------------------------------
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Returned 64 bits wide; callers keep the low dw bits.
  function automatic longint most_neg(input int dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/argmax_result_if.sv
// -----------------------------------------------------------------------------
// argmax_result_if
// Bundles the controller handshake and the pixel-memory read port of the
// argmax result stage.
//   enable        : level start/hold from the top-level controller
//   memstartp     : address of the first score word
//   qp            : memory read data, lane k at [(VALS_PER_WORD-k)*DATA_W-1 -: DATA_W]
//   read_addressp : memory read address
//   re            : memory read enable
//   RESULT        : winning class index
//   STOP          : done flag
//   MAXVAL        : winning score (only when ARGMAX_MAXVAL_EN is defined)
// Modports: master = controller/memory side, slave = argmax block.
// -----------------------------------------------------------------------------
interface argmax_result_if
  import argmax_pkg::*;
#(
  parameter int DATA_W        = 13,
  parameter int VALS_PER_WORD = 8,
  parameter int ADDR_W        = 13,
  parameter int CLASS_W       = clog2(10)
);

  logic                              enable;
  logic [ADDR_W-1:0]                 memstartp;
  logic [DATA_W*VALS_PER_WORD-1:0]   qp;
  logic [ADDR_W-1:0]                 read_addressp;
  logic                              re;
  logic [CLASS_W-1:0]                RESULT;
  logic                              STOP;
`ifdef ARGMAX_MAXVAL_EN
  logic signed [DATA_W-1:0]          MAXVAL;

  modport master (
    output enable, memstartp, qp,
    input  read_addressp, re, RESULT, STOP, MAXVAL
  );

  modport slave (
    input  enable, memstartp, qp,
    output read_addressp, re, RESULT, STOP, MAXVAL
  );
`else
  modport master (
    output enable, memstartp, qp,
    input  read_addressp, re, RESULT, STOP
  );

  modport slave (
    input  enable, memstartp, qp,
    output read_addressp, re, RESULT, STOP
  );
`endif

endinterface

// File: rtl/argmax_word_reduce.sv
// -----------------------------------------------------------------------------
// argmax_word_reduce
// Combinational reduction of one packed score word to its local maximum.
// Lanes are scanned in ascending class order and a lane replaces the current
// best when it is >= (signed), so ties resolve to the higher lane.
// Ports:
//   i_word : packed scores, lane k at [(VALS_PER_WORD-k)*DATA_W-1 -: DATA_W]
//   i_base : class index of lane 0
//   i_mask : lane-valid mask (bit k set = lane k holds a real class)
//   o_max  : local maximum score
//   o_idx  : class index of o_max
// -----------------------------------------------------------------------------
module argmax_word_reduce #(
  parameter int DATA_W        = 13,
  parameter int VALS_PER_WORD = 8,
  parameter int IDX_W         = 4
) (
  input  logic [DATA_W*VALS_PER_WORD-1:0] i_word,
  input  logic [IDX_W-1:0]                i_base,
  input  logic [VALS_PER_WORD-1:0]        i_mask,
  output logic signed [DATA_W-1:0]        o_max,
  output logic [IDX_W-1:0]                o_idx
);

  logic signed [DATA_W-1:0] w_lane;
  logic                     w_found;

  always_comb begin
    o_max   = '0;
    o_idx   = i_base;
    w_lane  = '0;
    w_found = 1'b0;
    for (int k = 0; k < VALS_PER_WORD; k++) begin
      w_lane = i_word[(VALS_PER_WORD-k)*DATA_W-1 -: DATA_W];
      if (i_mask[k] && (!w_found || (w_lane >= o_max))) begin
        o_max   = w_lane;
        o_idx   = i_base + IDX_W'(k);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/argmax_result.sv
// -----------------------------------------------------------------------------
// argmax_result
// Classifier result stage: reads NW = ceil(NUM_CLASSES/VALS_PER_WORD) packed
// score words starting at memstartp, merges each returning word into a running
// maximum and reports the winning class index on RESULT with STOP raised.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : argmax_result_if slave (enable, memstartp, qp, read_addressp,
//                re, RESULT, STOP, and MAXVAL when enabled)
// Optional feature: define ARGMAX_MAXVAL_EN to expose the winning score on
// MAXVAL, registered together with RESULT.
// Timing: STOP rises NW + RD_LAT + 1 edges after the first edge with enable=1.
// -----------------------------------------------------------------------------
module argmax_result
  import argmax_pkg::*;
#(
  parameter int DATA_W        = 13,
  parameter int VALS_PER_WORD = 8,
  parameter int NUM_CLASSES   = 10,
  parameter int ADDR_W        = 13,
  parameter int RD_LAT        = 2,
  parameter int CLASS_W       = clog2(NUM_CLASSES)
) (
  input  logic           clk,
  input  logic           rst_n,
  argmax_result_if.slave bus
);

  localparam int     NW    = (NUM_CLASSES + VALS_PER_WORD - 1) / VALS_PER_WORD;
  localparam int     CNT_W = clog2(NW + 1);
  localparam longint MN64  = most_neg(DATA_W);
  localparam logic signed [DATA_W-1:0] MOST_NEG = MN64[DATA_W-1:0];
  localparam logic [CNT_W-1:0]         NW_C     = CNT_W'(NW);

  state_t                   r_state;
  state_t                   w_next;
  logic [ADDR_W-1:0]        r_addr;
  logic                     r_re;
  logic                     r_stop;
  logic [CLASS_W-1:0]       r_result;
  logic [CNT_W-1:0]         r_icnt;     // addresses issued
  logic [CNT_W-1:0]         r_vcnt;     // words merged
  logic                     r_new;      // a fresh address is on the bus this cycle
  logic [RD_LAT-1:0]        r_vld;      // tags travelling with outstanding reads
  logic signed [DATA_W-1:0] r_best;
  logic [CLASS_W-1:0]       r_bidx;
`ifdef ARGMAX_MAXVAL_EN
  logic signed [DATA_W-1:0] r_maxval;
`endif

  logic [RD_LAT:0]          w_vld_in;
  logic                     w_qvld;
  logic [CLASS_W-1:0]       w_base;
  logic [VALS_PER_WORD-1:0] w_mask;
  logic signed [DATA_W-1:0] w_lmax;
  logic [CLASS_W-1:0]       w_lidx;
  logic                     w_take;

  // The top bit of the extended shift vector is the tag leaving the pipe,
  // i.e. qp carries a requested word this cycle.
  assign w_vld_in = {r_vld, r_new};
  assign w_qvld   = w_vld_in[RD_LAT];

  // Lanes past the last class in the final word are masked off.
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < VALS_PER_WORD; k++) begin
      w_mask[k] = ((int'(r_vcnt) * VALS_PER_WORD + k) < NUM_CLASSES);
    end
  end

  assign w_base = CLASS_W'(int'(r_vcnt) * VALS_PER_WORD);

  argmax_word_reduce #(
    .DATA_W        (DATA_W),
    .VALS_PER_WORD (VALS_PER_WORD),
    .IDX_W         (CLASS_W)
  ) u_reduce (
    .i_word (bus.qp),
    .i_base (w_base),
    .i_mask (w_mask),
    .o_max  (w_lmax),
    .o_idx  (w_lidx)
  );

  // Later words hold higher classes, so >= keeps the higher-index tie winner.
  assign w_take = (w_lmax >= r_best);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.enable) w_next = ISSUE;
      ISSUE:   if (!bus.enable) w_next = IDLE;
               else if (r_icnt == NW_C) w_next = DRAIN;
      DRAIN:   if (!bus.enable) w_next = IDLE;
               else if (r_vcnt == NW_C) w_next = DONE;
      DONE:    if (!bus.enable) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_re     <= 1'b0;
      r_stop   <= 1'b0;
      r_result <= '0;
      r_icnt   <= '0;
      r_vcnt   <= '0;
      r_new    <= 1'b0;
      r_vld    <= '0;
      r_best   <= '0;
      r_bidx   <= '0;
`ifdef ARGMAX_MAXVAL_EN
      r_maxval <= '0;
`endif
    end else begin
      r_new <= 1'b0;
      r_vld <= w_vld_in[RD_LAT-1:0];
      case (r_state)
        IDLE: begin
          if (bus.enable) begin
            r_addr <= bus.memstartp;
            r_re   <= 1'b1;
            r_stop <= 1'b0;
            r_best <= MOST_NEG;
            r_bidx <= '0;
            r_icnt <= CNT_W'(1);
            r_vcnt <= '0;
            r_new  <= 1'b1;
          end
        end
        ISSUE, DRAIN: begin
          if (!bus.enable) begin
            // Abort: drop outstanding tags so nothing merges later.
            r_re   <= 1'b0;
            r_stop <= 1'b0;
            r_vld  <= '0;
          end else begin
            if ((r_state == ISSUE) && (r_icnt != NW_C)) begin
              r_addr <= r_addr + ADDR_W'(1);
              r_icnt <= r_icnt + CNT_W'(1);
              r_new  <= 1'b1;
            end
            if (w_qvld) begin
              if (w_take) begin
                r_best <= w_lmax;
                r_bidx <= w_lidx;
              end
              r_vcnt <= r_vcnt + CNT_W'(1);
            end
            if ((r_state == DRAIN) && (r_vcnt == NW_C)) begin
              r_stop   <= 1'b1;
              r_re     <= 1'b0;
              r_result <= r_bidx;
`ifdef ARGMAX_MAXVAL_EN
              r_maxval <= r_best;
`endif
            end
          end
        end
        DONE: begin
          if (!bus.enable) r_stop <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.read_addressp = r_addr;
  assign bus.re            = r_re;
  assign bus.RESULT        = r_result;
  assign bus.STOP          = r_stop;
`ifdef ARGMAX_MAXVAL_EN
  assign bus.MAXVAL        = r_maxval;
`endif

endmodule

// File: tb/tb_argmax_result.sv
// -----------------------------------------------------------------------------
// tb_argmax_result
// Bench for argmax_result: a 10-class instance (two words) and a 2-class
// instance share one behavioural pixel memory with RD_LAT read latency.
// Expected winners come from a plain scan over the class scores.
// MAXVAL is checked when ARGMAX_MAXVAL_EN is defined.
// -----------------------------------------------------------------------------
module tb_argmax_result;

  localparam int DW   = 13;
  localparam int VPW  = 8;
  localparam int NC   = 10;
  localparam int AW   = 13;
  localparam int RL   = 2;
  localparam int NW   = 2;
  localparam int CW   = 4;
  localparam int NC_B = 2;
  localparam int CW_B = 1;
  localparam int WW   = DW * VPW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  argmax_result_if #(.DATA_W(DW), .VALS_PER_WORD(VPW), .ADDR_W(AW), .CLASS_W(CW))   bus_a ();
  argmax_result_if #(.DATA_W(DW), .VALS_PER_WORD(VPW), .ADDR_W(AW), .CLASS_W(CW_B)) bus_b ();

  argmax_result #(.DATA_W(DW), .VALS_PER_WORD(VPW), .NUM_CLASSES(NC), .ADDR_W(AW),
                  .RD_LAT(RL), .CLASS_W(CW)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  argmax_result #(.DATA_W(DW), .VALS_PER_WORD(VPW), .NUM_CLASSES(NC_B), .ADDR_W(AW),
                  .RD_LAT(RL), .CLASS_W(CW_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Behavioural memory: data appears RL cycles after the address cycle.
  logic [WW-1:0] mem [0:(1<<AW)-1];
  logic [WW-1:0] pipe_a [RL];
  logic [WW-1:0] pipe_b [RL];

  always @(posedge clk) begin
    pipe_a[0] <= mem[bus_a.read_addressp];
    pipe_b[0] <= mem[bus_b.read_addressp];
    for (int i = 1; i < RL; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
  end
  assign bus_a.qp = pipe_a[RL-1];
  assign bus_b.qp = pipe_b[RL-1];

  int n_vec = 0;
  int n_err = 0;
  int sc [NW*VPW];   // class scores followed by padding lanes

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic write_words(input logic [AW-1:0] start, input int nwords);
    logic [AW-1:0] a;
    for (int w = 0; w < nwords; w++) begin
      a = start + AW'(w);
      for (int k = 0; k < VPW; k++) begin
        mem[a][(VPW-k)*DW-1 -: DW] = sc[w*VPW+k][DW-1:0];
      end
    end
  endtask

  // Reference: scan classes in ascending order, later >= replaces earlier.
  function automatic int ref_best(input int n);
    int b;
    b = 0;
    for (int i = 1; i < n; i++) if (sc[i] >= sc[b]) b = i;
    return b;
  endfunction

  function automatic int rnd_score();
    return int'($urandom_range(8191)) - 4096;
  endfunction

  task automatic run_a(input logic [AW-1:0] start, input string tag);
    int exp_idx, cyc, relow;
    logic [AW-1:0] addrs [$];
    write_words(start, NW);
    exp_idx = ref_best(NC);
    @(negedge clk);
    bus_a.memstartp = start;
    bus_a.enable    = 1'b1;
    @(posedge clk); #1;
    cyc = 0; relow = 0;
    while (!bus_a.STOP && cyc < 60) begin
      if (bus_a.re) begin
        if (addrs.size() == 0 || addrs[$] != bus_a.read_addressp)
          addrs.push_back(bus_a.read_addressp);
      end else relow++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'(NW + RL + 1));
    check({tag, ".re_low_in_run"}, 64'(relow), 64'd0);
    check({tag, ".n_addr"}, 64'(addrs.size()), 64'(NW));
    for (int i = 0; i < NW && i < addrs.size(); i++)
      check({tag, ".addr"}, 64'(addrs[i]), 64'(AW'(start + AW'(i))));
    check({tag, ".result"}, 64'(bus_a.RESULT), 64'(exp_idx));
    check({tag, ".re_done"}, 64'(bus_a.re), 64'd0);
`ifdef ARGMAX_MAXVAL_EN
    check({tag, ".maxval"}, 64'($signed(bus_a.MAXVAL)), 64'(sc[exp_idx]));
`endif
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".stop_hold"}, 64'(bus_a.STOP), 64'd1);
    check({tag, ".re_hold"}, 64'(bus_a.re), 64'd0);
    @(negedge clk);
    bus_a.enable = 1'b0;
    @(posedge clk); #1;
    check({tag, ".stop_release"}, 64'(bus_a.STOP), 64'd0);
    check({tag, ".result_kept"}, 64'(bus_a.RESULT), 64'(exp_idx));
  endtask

  initial begin
    int cyc;
    bus_a.enable = 1'b0; bus_a.memstartp = '0;
    bus_b.enable = 1'b0; bus_b.memstartp = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    #1;
    check("reset.re", 64'(bus_a.re), 64'd0);
    check("reset.stop", 64'(bus_a.STOP), 64'd0);
    check("reset.result", 64'(bus_a.RESULT), 64'd0);
    check("reset.addr", 64'(bus_a.read_addressp), 64'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Two-class instance: scores {5, 9}, padding lanes random.
    for (int i = 0; i < VPW; i++) sc[i] = rnd_score();
    sc[0] = 5; sc[1] = 9;
    write_words(AW'(100), 1);
    @(negedge clk);
    bus_b.memstartp = AW'(100);
    bus_b.enable    = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    check("two.re_issue", 64'(bus_b.re), 64'd1);
    check("two.addr", 64'(bus_b.read_addressp), 64'd100);
    while (!bus_b.STOP && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("two.latency", 64'(cyc), 64'd4);
    check("two.result", 64'(bus_b.RESULT), 64'(ref_best(NC_B)));
`ifdef ARGMAX_MAXVAL_EN
    check("two.maxval", 64'($signed(bus_b.MAXVAL)), 64'd9);
`endif
    @(negedge clk);
    bus_b.enable = 1'b0;

    // Class 8 (second word, lane 0) wins.
    for (int i = 0; i < NW*VPW; i++) sc[i] = -100;
    sc[8] = 37;
    run_a(AW'(32), "cls8");

    // Tie between classes 3 and 7; padding lanes at max positive.
    for (int i = 0; i < NW*VPW; i++) sc[i] = (i >= NC) ? 4095 : -20;
    sc[3] = 50; sc[7] = 50;
    run_a(AW'(64), "tie");

    // Result 4, then an aborted run must leave it in place.
    for (int i = 0; i < NW*VPW; i++) sc[i] = 0;
    sc[4] = 1000;
    run_a(AW'(96), "four");
    for (int i = 0; i < NW*VPW; i++) sc[i] = -5;
    sc[9] = 2000;
    write_words(AW'(200), NW);
    @(negedge clk);
    bus_a.memstartp = AW'(200);
    bus_a.enable    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus_a.enable = 1'b0;
    @(posedge clk); #1;
    check("abort.stop", 64'(bus_a.STOP), 64'd0);
    check("abort.re", 64'(bus_a.re), 64'd0);
    check("abort.result", 64'(bus_a.RESULT), 64'd4);
    repeat (4) @(posedge clk);
    #1;
    check("abort.stop_later", 64'(bus_a.STOP), 64'd0);
    check("abort.result_later", 64'(bus_a.RESULT), 64'd4);
    run_a(AW'(200), "rerun");

    // Address wrap from the top of memory.
    for (int i = 0; i < NW*VPW; i++) sc[i] = rnd_score() / 4;
    sc[5] = 3000;
    run_a({AW{1'b1}}, "wrap");

    // Asynchronous reset in the middle of ISSUE.
    for (int i = 0; i < NW*VPW; i++) sc[i] = rnd_score();
    write_words(AW'(300), NW);
    @(negedge clk);
    bus_a.memstartp = AW'(300);
    bus_a.enable    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.re", 64'(bus_a.re), 64'd0);
    check("arst.stop", 64'(bus_a.STOP), 64'd0);
    check("arst.result", 64'(bus_a.RESULT), 64'd0);
    check("arst.addr", 64'(bus_a.read_addressp), 64'd0);
`ifdef ARGMAX_MAXVAL_EN
    check("arst.maxval", 64'($signed(bus_a.MAXVAL)), 64'd0);
`endif
    @(negedge clk);
    bus_a.enable = 1'b0;
    rst_n = 1'b1;
    run_a(AW'(300), "after_rst");

    // Randomized score sets, some from a narrow range to provoke ties.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NW*VPW; i++) begin
        if (r % 3 == 0) sc[i] = int'($urandom_range(6)) - 3;
        else            sc[i] = rnd_score();
      end
      run_a(AW'($urandom_range(4000, 512)), $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
